// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with a valid/ready handshake on both sides.
// Logic, add/sub, signed compare and shift complete in one cycle; MUL runs
// an unsigned shift-add multiplier for WIDTH cycles in a dedicated state.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset
//   InValid   request valid            InReady  block can accept this cycle
//   In1, In2  operands (WIDTH bits)    Sel      opcode (AND,OR,XOR,ADD,SUB,SLT,SLL,MUL)
//   Out       registered result, Out[WIDTH] = carry / borrow / unsigned overflow
//   Zero      Out[WIDTH-1:0] == 0      Ovf      signed overflow
//   OutValid  result present           OutReady consumer takes the result
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [2:0]       Sel,
  output logic [WIDTH:0]   Out,
  output logic             Zero,
  output logic             Ovf,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     out_q, out_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  // prod holds {partial high product, remaining multiplier bits}; it shifts
  // right once per iteration so the multiplier LSB is always prod_q[0].
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               accept_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     alu_res_s;
  logic               alu_ovf_s;
  logic [WIDTH:0]     step_sum_s;
  logic [2*WIDTH-1:0] prod_step_s;

  assign InReady  = (state_q == ST_IDLE) && (!out_valid_q || OutReady);
  assign accept_s = InValid && InReady;

  assign Out      = out_q;
  assign Zero     = zero_q;
  assign Ovf      = ovf_q;
  assign OutValid = out_valid_q;

  // Single-cycle datapath for every opcode except MUL.
  always_comb begin
    // A WIDTH+1 bit subtraction leaves the unsigned borrow in the top bit.
    add_s     = {1'b0, In1} + {1'b0, In2};
    sub_s     = {1'b0, In1} - {1'b0, In2};
    alu_res_s = {(WIDTH+1){1'b0}};
    alu_ovf_s = 1'b0;
    case (Sel)
      OP_AND: alu_res_s = {1'b0, In1 & In2};
      OP_OR:  alu_res_s = {1'b0, In1 | In2};
      OP_XOR: alu_res_s = {1'b0, In1 ^ In2};
      OP_ADD: begin
        alu_res_s = add_s;
        alu_ovf_s = (In1[WIDTH-1] == In2[WIDTH-1]) && (add_s[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_ovf_s = (In1[WIDTH-1] != In2[WIDTH-1]) && (sub_s[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_SLT: alu_res_s = {{WIDTH{1'b0}}, ($signed(In1) < $signed(In2))};
      OP_SLL: alu_res_s = {1'b0, In1 << In2[SHW-1:0]};
      default: begin
        alu_res_s = {(WIDTH+1){1'b0}};
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // One shift-add multiplier iteration.
  always_comb begin
    step_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step_s = {step_sum_s, prod_q[WIDTH-1:1]};
  end

  // Next-state and result-register logic for the IDLE/MUL controller.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (Sel == OP_MUL) begin
            state_d     = ST_MUL;
            prod_d      = {{WIDTH{1'b0}}, In2};
            mcand_d     = In1;
            cnt_d       = {SHW{1'b0}};
            // Accept implies any pending result is being consumed now.
            out_valid_d = 1'b0;
          end else begin
            out_d       = alu_res_s;
            zero_d      = (alu_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
            ovf_d       = alu_ovf_s;
            out_valid_d = 1'b1;
          end
        end else if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_MUL: begin
        prod_d = prod_step_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          out_d       = {|prod_step_s[2*WIDTH-1:WIDTH], prod_step_s[WIDTH-1:0]};
          zero_d      = (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
        end else if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      out_q       <= {(WIDTH+1){1'b0}};
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= {(2*WIDTH){1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      cnt_q       <= {SHW{1'b0}};
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed vectors push expected
// results on accept; a monitor pops and compares on each output handshake.
module tb_alu_seq;

  logic        Clk;
  logic        Rst;
  logic        InValid;
  logic        InReady;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [2:0]  Sel;
  logic [32:0] Out;
  logic        Zero;
  logic        Ovf;
  logic        OutValid;
  logic        OutReady;

  typedef struct {
    logic [32:0] out;
    logic        zero;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .In1(In1), .In2(In2), .Sel(Sel), .Out(Out), .Zero(Zero), .Ovf(Ovf),
    .OutValid(OutValid), .OutReady(OutReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every result the consumer takes against the scoreboard.
  always @(negedge Clk) begin
    if (!Rst && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected no result", Out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_out"},  {31'd0, Out},  {31'd0, e.out});
        check({e.name, "_zero"}, {63'd0, Zero}, {63'd0, e.zero});
        check({e.name, "_ovf"},  {63'd0, Ovf},  {63'd0, e.ovf});
      end
    end
  end

  // Drive one request, wait (bounded) for accept, push its expected result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                       input logic [32:0] eo, input logic ez, input logic eov,
                       input string nm);
    logic acc;
    exp_t e;
    acc = 1'b0;
    In1 = a; In2 = b; Sel = s; InValid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge Clk);
      if (InReady) begin
        e.out = eo; e.zero = ez; e.ovf = eov; e.name = nm;
        exp_q.push_back(e);
        acc = 1'b1;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    check({nm, "_accepted"}, {63'd0, acc}, 64'd1);
  endtask

  // MUL with latency / InReady measurement and input scrambling during MUL.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] eo, input logic ez, input string nm);
    int lat;
    int low_cnt;
    logic seen;
    issue(a, b, 3'd7, eo, ez, 1'b0, nm);
    In1 = $urandom; In2 = $urandom; Sel = 3'd3; InValid = 1'b1;
    lat = 0; low_cnt = 0; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge Clk);
      if (OutValid) begin
        seen = 1'b1;
        lat  = k;
      end else if (!InReady) begin
        low_cnt++;
      end else begin
        low_cnt = low_cnt;
      end
      @(posedge Clk); #1;
      if (k == 20) InValid = 1'b0;
    end
    InValid = 1'b0;
    check({nm, "_latency"}, lat, 64'd33);
    check({nm, "_inready_low_cycles"}, low_cnt, 64'd32);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    int wait_cnt;
    Rst = 1'b1; InValid = 1'b0; In1 = 32'd0; In2 = 32'd0; Sel = 3'd0; OutReady = 1'b1;

    // Reset state while Rst is held
    @(posedge Clk); @(negedge Clk);
    check("rst_out",      {31'd0, Out},      64'd0);
    check("rst_zero",     {63'd0, Zero},     64'd0);
    check("rst_ovf",      {63'd0, Ovf},      64'd0);
    check("rst_outvalid", {63'd0, OutValid}, 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_inready", {63'd0, InReady}, 64'd1);
    @(posedge Clk); #1;

    // Back-to-back single-cycle ops with OutReady=1
    issue(32'hFFFF_FFFF, 32'h1,         3'd3, 33'h1_0000_0000, 1'b1, 1'b0, "add_carry");
    @(negedge Clk);
    check("add_next_cycle_valid", {63'd0, OutValid}, 64'd1);
    @(posedge Clk); #1;
    issue(32'h8000_0000, 32'h1,         3'd4, 33'h0_7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
    issue(32'h1,         32'h2,         3'd4, 33'h1_FFFF_FFFF, 1'b0, 1'b0, "sub_borrow");
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 33'h0_00F0_00F0, 1'b0, 1'b0, "and");
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd1, 33'h0_FFF0_FFF0, 1'b0, 1'b0, "or");
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 33'h0_FF00_FF00, 1'b0, 1'b0, "xor");
    issue(32'hFFFF_FFFF, 32'h1,         3'd5, 33'h0_0000_0001, 1'b0, 1'b0, "slt_true");
    issue(32'h1,         32'hFFFF_FFFF, 3'd5, 33'h0_0000_0000, 1'b1, 1'b0, "slt_false");
    issue(32'h1,         32'h25,        3'd6, 33'h0_0000_0020, 1'b0, 1'b0, "sll");
    issue(32'h7FFF_FFFF, 32'h1,         3'd3, 33'h0_8000_0000, 1'b0, 1'b1, "add_ovf");
    issue(32'h5,         32'h5,         3'd2, 33'h0_0000_0000, 1'b1, 1'b0, "xor_zero");

    // Multiplies
    mul_op(32'h0001_0000, 32'h0001_0000, 33'h1_0000_0000, 1'b1, "mul_ovf_zero");
    mul_op(32'd12345,     32'd100,       33'h0_0012_D644, 1'b0, "mul_small");
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_0000_0001, 1'b0, "mul_max");

    // Backpressure: ADD result held while XOR waits
    OutReady = 1'b0;
    issue(32'd3, 32'd4, 3'd3, 33'h0_0000_0007, 1'b0, 1'b0, "bp_add");
    In1 = 32'd5; In2 = 32'd6; Sel = 3'd2; InValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("bp_hold_out",      {31'd0, Out},      64'd7);
      check("bp_hold_valid",    {63'd0, OutValid}, 64'd1);
      check("bp_hold_inready",  {63'd0, InReady},  64'd0);
      @(posedge Clk); #1;
    end
    OutReady = 1'b1;
    begin
      exp_t e;
      @(negedge Clk);
      check("bp_xor_inready", {63'd0, InReady}, 64'd1);
      e.out = 33'h0_0000_0003; e.zero = 1'b0; e.ovf = 1'b0; e.name = "bp_xor";
      if (InReady) exp_q.push_back(e);
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    @(negedge Clk);
    check("bp_xor_valid", {63'd0, OutValid}, 64'd1);
    @(posedge Clk); #1;

    // Drain, then reset during the 10th MUL cycle
    wait_cnt = 0;
    while ((exp_q.size() != 0 || OutValid) && wait_cnt < 100) begin
      @(posedge Clk); #1;
      wait_cnt++;
    end
    check("drain_before_reset", exp_q.size(), 64'd0);
    In1 = 32'h0001_0000; In2 = 32'h0001_0000; Sel = 3'd7; InValid = 1'b1;
    wait_cnt = 0;
    @(negedge Clk);
    while (!InReady && wait_cnt < 100) begin
      @(negedge Clk);
      wait_cnt++;
    end
    check("rst_mul_accept", {63'd0, InReady}, 64'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge Clk); #1;
    end
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_mul_outvalid", {63'd0, OutValid}, 64'd0);
    check("rst_mul_out",      {31'd0, Out},      64'd0);
    check("rst_mul_inready",  {63'd0, InReady},  64'd1);
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (OutValid) stale++;
    end
    check("rst_mul_no_stale", stale, 64'd0);
    check("scoreboard_empty", exp_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width; SHALL be a power of two, 8..64.
REQ-002 Port: Clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 Port: Rst  input  1  synchronous, active-high reset; SHALL be sampled on the rising edge of Clk.
REQ-004 Port: InValid  input  1  operation request valid.
REQ-005 Port: InReady  output  1  block can accept an operation this cycle.
REQ-006 Port: In1  input  WIDTH  operand A.
REQ-007 Port: In2  input  WIDTH  operand B.
REQ-008 Port: Sel  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 SLL, 7 MUL.
REQ-009 Port: Out  output  WIDTH+1  registered result; Out[WIDTH] is the carry, borrow or overflow bit.
REQ-010 Port: Zero  output  1  Out[WIDTH-1:0] == 0, registered with Out.
REQ-011 Port: Ovf  output  1  signed overflow, registered with Out.
REQ-012 Port: OutValid  output  1  Out/Zero/Ovf hold a result.
REQ-013 Port: OutReady  input  1  consumer accepts the result this cycle.

Function
REQ-014 Accept SHALL occur in a cycle where InValid=1 and InReady=1; In1, In2 and Sel SHALL be captured only on accept.
REQ-015 InReady SHALL equal (state==IDLE) AND (OutValid==0 OR OutReady==1), combinational on OutReady.
REQ-016 FSM states SHALL be IDLE and MUL; accept with Sel=7 moves IDLE->MUL; any other accept stays in IDLE.
REQ-017 Non-MUL ops: result SHALL be registered at the edge ending accept cycle N, OutValid=1 from cycle N+1; back-to-back throughput SHALL be one op per cycle when OutReady=1.
REQ-018 MUL: unsigned shift-add over exactly WIDTH iterations in MUL state; OutValid=1 from cycle N+WIDTH+1, then state returns to IDLE.
REQ-019 Result held: while OutValid=1 and OutReady=0, Out/Zero/Ovf/OutValid SHALL remain stable.
REQ-020 OutValid SHALL clear on the edge where OutValid=1 and OutReady=1 unless a new non-MUL result is loaded on that same edge.
REQ-021 AND/OR/XOR: Out = {0, bitwise result}; Ovf=0.
REQ-022 ADD: Out = zero-extended In1 + zero-extended In2 (Out[WIDTH] = carry); Ovf = signed overflow.
REQ-023 SUB: Out[WIDTH-1:0] = In1 - In2 modulo 2^WIDTH; Out[WIDTH] = 1 iff In1 < In2 unsigned (borrow); Ovf = signed overflow.
REQ-024 SLT: Out = 1 if In1 < In2 signed, else 0; Ovf=0.
REQ-025 SLL: Out = {0, In1 << In2[log2(WIDTH)-1:0]}; upper In2 bits ignored; Ovf=0.
REQ-026 MUL: Out[WIDTH-1:0] = low WIDTH bits of the product; Out[WIDTH] = OR of the high WIDTH product bits (unsigned overflow); Ovf=0.
REQ-027 Zero SHALL reflect Out[WIDTH-1:0] for every opcode, including MUL.
REQ-028 InValid while InReady=0 SHALL be ignored; In1/In2/Sel changes during MUL SHALL NOT affect the result.

Reset
REQ-029 With Rst=1 at an edge: state=IDLE, Out=0, Zero=0, Ovf=0, OutValid=0, MUL accumulator and counter cleared.
REQ-030 Rst SHALL take priority over accept and handshake; reset mid-MUL SHALL abort with no OutValid pulse, and InReady=1 in the cycle after reset deasserts.

Verification (WIDTH=32)
REQ-031 ADD: In1=0xFFFFFFFF, In2=1 -> next cycle OutValid=1, Out=0x1_00000000, Zero=1, Ovf=0.
REQ-032 SUB: In1=0x80000000, In2=1 -> Out=0x0_7FFFFFFF, Ovf=1; In1=1, In2=2 -> Out=0x1_FFFFFFFF, Ovf=0.
REQ-033 MUL: In1=In2=0x00010000 -> InReady=0 for 32 cycles, OutValid=1 exactly 33 cycles after accept, Out=0x1_00000000, Zero=1.
REQ-034 Backpressure: OutReady=0, ADD 3+4 then XOR queued -> Out=0x7 held stable, InReady=0; XOR accepted in the first cycle OutReady=1, result next cycle.
REQ-035 Reset at 10th MUL cycle -> following cycle OutValid=0, Out=0, InReady=1; no stale result ever appears.
REQ-036 SLT: 0xFFFFFFFF vs 1 -> Out=1. SLL: In1=1, In2=0x25 -> Out=0x20.
